uart_tx_serializer: RTL and testbench

- UART transmit stage placed directly downstream of the baud clock divider.
- Consumes the divider's toggling baud clock (synchronous to clk) and derives a one-cycle bit tick from its rising edge.
- Accepts bytes over a valid/ready handshake and serialises each byte as a frame:
  - start bit, then 8 data bits LSB-first;
  - optional parity bit;
  - 1 or 2 stop bits.
- Drives the idle-high tx line.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_edge_tick.sv | 19 +
 rtl/uart_tx_serializer.sv | 124 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and the line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;

endpackage

// File: rtl/uart_edge_tick.sv
// Turns the divider's toggling baud clock into a one-cycle tick on its rising edge.
module uart_edge_tick (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_uart_i,
  output logic tick_o
);

  logic clk_uart_q;

  // Reset high so a baud clock that is already high gives no tick at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_uart_q <= 1'b1;
    else        clk_uart_q <= clk_uart_i;
  end

  assign tick_o = clk_uart_i & ~clk_uart_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake, start/data/parity/stop framing on tx.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_uart,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [2:0]           bit_cnt_q;
  logic [0:0]           stop_cnt_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 tick;

  uart_edge_tick u_tick (
    .clk        (clk),
    .rst_n      (reset),
    .clk_uart_i (clk_uart),
    .tick_o     (tick)
  );

  assign shift_nxt = shift_q >> 1;

  // IDLE ignores tick, so a handshake coinciding with a tick starts on the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      parity_q   <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (tx_valid && ready_q) begin
            shift_q  <= tx_data;
            parity_q <= (^tx_data) ^ PARITY_ODD;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (tick) begin
            tx_q    <= START_LEVEL;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q      <= shift_q[0];
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q != 3'(DATA_BITS - 1)) begin
              shift_q   <= shift_nxt;
              tx_q      <= shift_nxt[0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end else if (PARITY_EN) begin
              tx_q    <= parity_q;
              state_q <= PARITY;
            end else begin
              tx_q       <= UART_IDLE_LEVEL;
              stop_cnt_q <= '0;
              state_q    <= STOP;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q       <= UART_IDLE_LEVEL;
            stop_cnt_q <= '0;
            state_q    <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt_q != 1'(STOP_BITS - 1)) begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end else begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= UART_IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: default-configured transmitter plus an even-parity, two-stop-bit instance.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_uart = 1'b0;
  int         ucnt = 0;

  logic [7:0] tx_data0 = '0;
  logic       tx_valid0 = 1'b0;
  logic       tx_ready0, tx0, busy0;

  logic [7:0] tx_data1 = '0;
  logic       tx_valid1 = 1'b0;
  logic       tx_ready1, tx1, busy1;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_serializer dut0 (
    .clk      (clk),
    .reset    (reset),
    .clk_uart (clk_uart),
    .tx_data  (tx_data0),
    .tx_valid (tx_valid0),
    .tx_ready (tx_ready0),
    .tx       (tx0),
    .busy     (busy0)
  );

  uart_tx_serializer #(
    .DATA_BITS  (8),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (1'b0),
    .STOP_BITS  (2)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .clk_uart (clk_uart),
    .tx_data  (tx_data1),
    .tx_valid (tx_valid1),
    .tx_ready (tx_ready1),
    .tx       (tx1),
    .busy     (busy1)
  );

  always #5 clk = ~clk;

  // Baud clock toggles every 4 clk cycles on the falling edge: one bit = 8 cycles.
  always @(negedge clk) begin
    ucnt = ucnt + 1;
    if (ucnt == 4) begin
      ucnt = 0;
      clk_uart = ~clk_uart;
    end
  end

  function automatic logic get_tx(int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_ready(int sel);
    return (sel == 0) ? tx_ready0 : tx_ready1;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(int sel, string tag, output int w);
    w = 0;
    do begin
      cyc(1);
      w++;
    end while (get_tx(sel) !== 1'b0 && w < 20);
    chk({tag, "_start_seen"}, 32'(get_tx(sel)), 32'd0);
  endtask

  // Entered one cycle after the start bit begins; samples mid-bit every 8 cycles.
  task automatic check_bits(int sel, int n, logic [15:0] exp, string tag);
    logic bad_ready;
    bad_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) cyc(4);
      else        cyc(8);
      chk($sformatf("%s_bit%0d", tag, k), 32'(get_tx(sel)), 32'(exp[k]));
      if (get_ready(sel) !== 1'b0) bad_ready = 1'b1;
    end
    chk({tag, "_ready_low"}, 32'(bad_ready), 32'd0);
  endtask

  initial begin
    int   w;
    logic all_one;

    // 1: reset and idle
    #1 reset = 1'b0;
    cyc(3);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_ready", 32'(tx_ready0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_tx_p", 32'(tx1), 32'd1);
    reset = 1'b1;
    all_one = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      all_one = all_one & tx0 & tx1;
    end
    chk("idle_tx_high", 32'(all_one), 32'd1);

    // 2: 0xA5, default framing
    tx_data0 = 8'hA5; tx_valid0 = 1'b1;
    cyc(1);
    tx_valid0 = 1'b0;
    chk("a5_ready_drop", 32'(tx_ready0), 32'd0);
    chk("a5_busy", 32'(busy0), 32'd1);
    wait_start(0, "a5", w);
    check_bits(0, 10, 16'b0000_0011_0100_1010, "a5");
    cyc(3);
    chk("a5_ready_before_tick", 32'(tx_ready0), 32'd0);
    cyc(1);
    chk("a5_ready_after_stop", 32'(tx_ready0), 32'd1);
    chk("a5_busy_after_stop", 32'(busy0), 32'd0);

    // 3: 0x07, even parity, two stop bits
    tx_data1 = 8'h07; tx_valid1 = 1'b1;
    cyc(1);
    tx_valid1 = 1'b0;
    wait_start(1, "p07", w);
    check_bits(1, 12, 16'b0000_1110_0000_1110, "p07");
    cyc(3);
    chk("p07_ready_before_tick", 32'(tx_ready1), 32'd0);
    cyc(1);
    chk("p07_ready_after_stop", 32'(tx_ready1), 32'd1);

    // 4: back-to-back 0x55 then 0xFF, valid held high
    tx_data0 = 8'h55; tx_valid0 = 1'b1;
    cyc(1);
    tx_data0 = 8'hFF;
    wait_start(0, "b2b1", w);
    check_bits(0, 10, 16'b0000_0010_1010_1010, "b2b1");
    cyc(4);
    chk("b2b_ready_idle", 32'(tx_ready0), 32'd1);
    cyc(1);
    tx_valid0 = 1'b0;
    chk("b2b_ready_taken", 32'(tx_ready0), 32'd0);
    wait_start(0, "b2b2", w);
    chk("b2b_gap", 32'(w), 32'd7);
    check_bits(0, 10, 16'b0000_0011_1111_1110, "b2b2");
    cyc(4);
    chk("b2b_busy_end", 32'(busy0), 32'd0);

    // 5: reset during data bit 3 of 0x00
    tx_data0 = 8'h00; tx_valid0 = 1'b1;
    cyc(1);
    tx_valid0 = 1'b0;
    wait_start(0, "rmid", w);
    cyc(36);
    chk("rmid_tx_low", 32'(tx0), 32'd0);
    #1 reset = 1'b0;
    #1;
    chk("rmid_tx_async", 32'(tx0), 32'd1);
    chk("rmid_ready", 32'(tx_ready0), 32'd1);
    chk("rmid_busy", 32'(busy0), 32'd0);
    cyc(2);
    reset = 1'b1;
    all_one = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      all_one = all_one & tx0 & tx_ready0 & ~busy0;
    end
    chk("rmid_no_residue", 32'(all_one), 32'd1);

    // 6: handshake on the tick edge; start waits for the next tick
    @(posedge clk_uart);
    tx_data0 = 8'h3C; tx_valid0 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid0 = 1'b0;
    chk("tick_hs_tx_idle", 32'(tx0), 32'd1);
    wait_start(0, "tick_hs", w);
    chk("tick_hs_delay", 32'(w), 32'd8);
    check_bits(0, 10, 16'b0000_0010_0111_1000, "tick_hs");
    cyc(4);
    chk("tick_hs_ready_end", 32'(tx_ready0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
